// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;
  localparam int REG_AW_DEF   = 5;
  localparam int ZERO_REG_DEF = 31;
  // rd field is sized for the widest register file we expect; narrower addresses zero-extend
  localparam int RD_W         = 8;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            is_load;
    logic            sets_flags;
  } shadow_t;
endpackage

// File: rtl/pipe_hazard_unit_fwd_match.sv
// Per-read-port matcher: picks the youngest forwardable producer and flags a load in EX.
module fwd_match import pipe_pkg::*; #(
  parameter int REG_AW           = REG_AW_DEF,
  parameter int ZERO_REG         = ZERO_REG_DEF,
  parameter int FWD_DEPTH        = 3,
  parameter int RF_WRITE_THROUGH = 1,
  parameter int SEL_W            = $clog2(FWD_DEPTH+1)
)(
  input  logic [REG_AW-1:0]          src,
  input  logic                       used,
  input  shadow_t [FWD_DEPTH-1:0]    entries,
  output logic [SEL_W-1:0]           sel,
  output logic                       load_hit
);
  logic [FWD_DEPTH-1:0] hit;
  logic                 src_ok;
  logic                 unused_fields;

  assign src_ok = used && (src != REG_AW'(ZERO_REG));

  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_hit
    assign hit[k] = src_ok && entries[k].valid && entries[k].reg_write &&
                    (entries[k].rd == RD_W'(src));
  end

  // Scan oldest to youngest so the youngest forwardable hit wins.
  always_comb begin
    sel = '0;
    for (int k = FWD_DEPTH-1; k >= 0; k--) begin
      if (hit[k] && !(RF_WRITE_THROUGH != 0 && k == FWD_DEPTH-1))
        sel = SEL_W'(k+1);
    end
  end

  assign load_hit      = hit[0] && entries[0].is_load;
  assign unused_fields = ^entries;
endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: shadow rd pipeline, forwarding selects, load-use stall,
// branch flush and saturating stall/flush counters.
module pipe_hazard_unit import pipe_pkg::*; #(
  parameter int REG_AW           = REG_AW_DEF,
  parameter int ZERO_REG         = ZERO_REG_DEF,
  parameter int FWD_DEPTH        = 3,
  parameter int RF_WRITE_THROUGH = 1,
  parameter int CNT_W            = 16,
  localparam int SEL_W           = $clog2(FWD_DEPTH+1)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_sets_flags,
  input  logic              id_uses_flags,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [SEL_W-1:0]  fwd_sel1,
  output logic [SEL_W-1:0]  fwd_sel2,
  output logic              fwd_flags,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  shadow_t [FWD_DEPTH-1:0] entries;
  shadow_t                 id_entry;
  logic                    hit1, hit2, accept;

  fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .FWD_DEPTH(FWD_DEPTH),
              .RF_WRITE_THROUGH(RF_WRITE_THROUGH), .SEL_W(SEL_W)) u_match1 (
    .src(id_rs1), .used(id_rs1_used), .entries(entries), .sel(fwd_sel1), .load_hit(hit1));

  fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .FWD_DEPTH(FWD_DEPTH),
              .RF_WRITE_THROUGH(RF_WRITE_THROUGH), .SEL_W(SEL_W)) u_match2 (
    .src(id_rs2), .used(id_rs2_used), .entries(entries), .sel(fwd_sel2), .load_hit(hit2));

  // Flush wins over stall; reset forces both low even if br_taken is floating high.
  assign flush     = !reset && id_valid && br_taken;
  assign stall     = !reset && id_valid && (hit1 || hit2) && !flush;
  assign fwd_flags = id_uses_flags && entries[0].valid && entries[0].sets_flags;
  assign accept    = id_valid && !stall && !flush;

  always_comb begin
    id_entry            = '0;
    id_entry.valid      = 1'b1;
    id_entry.rd         = RD_W'(id_rd);
    id_entry.reg_write  = id_reg_write;
    id_entry.is_load    = id_is_load;
    id_entry.sets_flags = id_sets_flags;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries <= '0;
    end else begin
      for (int k = FWD_DEPTH-1; k > 0; k--) entries[k] <= entries[k-1];
      entries[0] <= accept ? id_entry : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench: two DUTs (write-through / full forwarding, 16-bit / 4-bit counters)
// fed the same decode stream and checked against an instruction-history model.
module tb_pipe_hazard_unit;
  logic clk = 0, reset = 1;
  logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic id_reg_write = 0, id_is_load = 0, id_sets_flags = 0, id_uses_flags = 0, br_taken = 0;

  logic stall_a, flush_a, flags_a, stall_b, flush_b, flags_b;
  logic [1:0] sel1_a, sel2_a, sel1_b, sel2_b;
  logic [15:0] scnt_a, fcnt_a;
  logic [3:0]  scnt_b, fcnt_b;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.RF_WRITE_THROUGH(1), .CNT_W(16)) dut_wt (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_sets_flags(id_sets_flags),
    .id_uses_flags(id_uses_flags), .br_taken(br_taken), .stall(stall_a), .flush(flush_a),
    .fwd_sel1(sel1_a), .fwd_sel2(sel2_a), .fwd_flags(flags_a),
    .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

  pipe_hazard_unit #(.RF_WRITE_THROUGH(0), .CNT_W(4)) dut_nw (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_sets_flags(id_sets_flags),
    .id_uses_flags(id_uses_flags), .br_taken(br_taken), .stall(stall_b), .flush(flush_b),
    .fwd_sel1(sel1_b), .fwd_sel2(sel2_b), .fwd_flags(flags_b),
    .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

  typedef struct {
    bit v; int rs1, rs2; bit u1, u2; int rd; bit rw, ld, sf, uf, br;
  } stim_t;
  typedef struct { bit v; int rd; bit rw, ld, sf; } instr_t;
  typedef struct {
    bit stall, flush, flags; int s1wt, s2wt, s1nw, s2nw, sc16, fc16, sc4, fc4;
  } exp_t;

  instr_t hist[$];
  exp_t   sb[$];
  int checks = 0, errors = 0;
  int scnt = 0, fcnt = 0;
  bit prev_rst = 1, prev_accept = 0, prev_stall = 0, prev_flush = 0;
  instr_t prev_instr;
  stim_t  cur;

  function automatic stim_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd,
                               bit rw, bit ld, bit sf, bit uf, bit br);
    stim_t s;
    s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
    s.rw = rw; s.ld = ld; s.sf = sf; s.uf = uf; s.br = br;
    return s;
  endfunction

  // hist[i] is the instruction i+1 stages past decode (0 = EX).
  function automatic bit produces(int i, int src, bit used);
    return used && src != 31 && hist[i].v && hist[i].rw && hist[i].rd == src;
  endfunction

  // Youngest producer still in flight; with write-through the WB stage reads from the RF.
  function automatic int pick(int src, bit used, bit wt);
    for (int i = 0; i < 3; i++) begin
      if (wt && i == 2) continue;
      if (produces(i, src, used)) return i + 1;
    end
    return 0;
  endfunction

  task automatic cycle(input bit rst_now, input stim_t s);
    exp_t e;
    instr_t bub;
    bit lu;
    bub = '{default: 0};
    @(posedge clk);
    if (!prev_rst) begin
      hist.push_front(prev_accept ? prev_instr : bub);
      void'(hist.pop_back());
      if (prev_stall) scnt++;
      if (prev_flush) fcnt++;
    end
    #1;
    reset = rst_now; cur = s;
    id_valid = s.v; id_rs1 = 5'(s.rs1); id_rs2 = 5'(s.rs2);
    id_rs1_used = s.u1; id_rs2_used = s.u2; id_rd = 5'(s.rd);
    id_reg_write = s.rw; id_is_load = s.ld; id_sets_flags = s.sf;
    id_uses_flags = s.uf; br_taken = s.br;
    e = '{default: 0};
    if (rst_now) begin
      hist = '{bub, bub, bub};
      scnt = 0; fcnt = 0;
    end else begin
      lu = (produces(0, s.rs1, s.u1) || produces(0, s.rs2, s.u2)) && hist[0].ld;
      e.flush = s.v && s.br;
      e.stall = s.v && lu && !e.flush;
      e.flags = s.uf && hist[0].v && hist[0].sf;
      e.s1wt = pick(s.rs1, s.u1, 1); e.s2wt = pick(s.rs2, s.u2, 1);
      e.s1nw = pick(s.rs1, s.u1, 0); e.s2nw = pick(s.rs2, s.u2, 0);
      e.sc16 = scnt > 65535 ? 65535 : scnt;  e.fc16 = fcnt > 65535 ? 65535 : fcnt;
      e.sc4  = scnt > 15 ? 15 : scnt;        e.fc4  = fcnt > 15 ? 15 : fcnt;
    end
    sb.push_back(e);
    prev_rst = rst_now; prev_stall = e.stall; prev_flush = e.flush;
    prev_accept = s.v && !e.stall && !e.flush && !rst_now;
    prev_instr = '{v: 1, rd: s.rd, rw: s.rw, ld: s.ld, sf: s.sf};
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_wt", int'(stall_a), int'(e.stall)); chk("stall_nw", int'(stall_b), int'(e.stall));
        chk("flush_wt", int'(flush_a), int'(e.flush)); chk("flush_nw", int'(flush_b), int'(e.flush));
        chk("flags_wt", int'(flags_a), int'(e.flags)); chk("flags_nw", int'(flags_b), int'(e.flags));
        chk("sel1_wt", int'(sel1_a), e.s1wt); chk("sel2_wt", int'(sel2_a), e.s2wt);
        chk("sel1_nw", int'(sel1_b), e.s1nw); chk("sel2_nw", int'(sel2_b), e.s2nw);
        chk("stall_cnt16", int'(scnt_a), e.sc16); chk("flush_cnt16", int'(fcnt_a), e.fc16);
        chk("stall_cnt4", int'(scnt_b), e.sc4);   chk("flush_cnt4", int'(fcnt_b), e.fc4);
      end
    end
  end

  initial begin : driver
    stim_t nop, s;
    int regs[4] = '{1, 2, 3, 31};
    int wait_cyc;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hist = '{'{default: 0}, '{default: 0}, '{default: 0}};
    prev_instr = '{default: 0};
    cycle(1, nop); cycle(1, nop);
    // ADD X1,X2,X3 ; SUB X4,X1,X5
    cycle(0, mk(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0));
    cycle(0, mk(1, 1, 5, 1, 1, 4, 1, 0, 0, 0, 0));
    cycle(0, nop); cycle(0, nop); cycle(0, nop);
    // LDUR X1 ; ADD X2,X1,X1 (held while stalled)
    cycle(0, mk(1, 6, 0, 1, 0, 1, 1, 1, 0, 0, 0));
    cycle(0, mk(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0));
    cycle(0, mk(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0));
    // ADD X31 ; ADD X5,X31,X31
    cycle(0, mk(1, 2, 3, 1, 1, 31, 1, 0, 0, 0, 0));
    cycle(0, mk(1, 31, 31, 1, 1, 5, 1, 0, 0, 0, 0));
    // Producer three ahead: WB stage
    cycle(0, mk(1, 2, 3, 1, 1, 9, 1, 0, 0, 0, 0));
    cycle(0, mk(1, 2, 3, 1, 1, 10, 0, 0, 0, 0, 0));
    cycle(0, mk(1, 2, 3, 1, 1, 11, 0, 0, 0, 0, 0));
    cycle(0, mk(1, 9, 9, 1, 1, 12, 1, 0, 0, 0, 0));
    // Load-use with a taken branch: flush wins, squashed X7 writer must not forward
    cycle(0, mk(1, 6, 0, 1, 0, 3, 1, 1, 0, 0, 0));
    cycle(0, mk(1, 3, 0, 1, 0, 7, 1, 0, 0, 0, 1));
    cycle(0, mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 0));
    // Flag producer then B.cond
    cycle(0, mk(1, 2, 3, 1, 1, 4, 1, 0, 1, 0, 0));
    cycle(0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // Reset in the middle of a load-use stall, then release
    cycle(0, mk(1, 6, 0, 1, 0, 2, 1, 1, 0, 0, 0));
    cycle(0, mk(1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 0));
    cycle(1, mk(1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 1));
    cycle(0, mk(1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 0));
    // Random stream; a stalled instruction is re-presented unchanged
    s = nop;
    for (int n = 0; n < 1500; n++) begin
      if (!prev_stall) begin
        s.v  = $urandom_range(0, 9) != 0;
        s.rs1 = regs[$urandom_range(0, 3)]; s.rs2 = regs[$urandom_range(0, 3)];
        s.u1 = $urandom_range(0, 3) != 0;   s.u2 = $urandom_range(0, 1) != 0;
        s.rd = regs[$urandom_range(0, 3)];
        s.rw = $urandom_range(0, 4) != 0;   s.ld = $urandom_range(0, 2) == 0;
        s.sf = $urandom_range(0, 1) != 0;   s.uf = $urandom_range(0, 2) == 0;
      end
      s.br = $urandom_range(0, 7) == 0;
      cycle((n % 500) == 250, s);
    end
    cycle(0, nop);
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the pipelined ARM datapath. It keeps a shadow pipeline of destination-register tags for every stage after decode. From that it does four things: selects forwarding sources for both decode-stage read ports, interlocks load-use hazards with a one-cycle stall, squashes on taken branches, and counts stall and flush events. It sits beside the decode stage and drives the pipeline-register enables and the operand forwarding muxes.

## Interface
- REG_AW, 5: register address width.
- ZERO_REG, 31: hardwired-zero register index; never a forwarding source.
- FWD_DEPTH, 3: number of tracked stages after decode (entry 0 = EX, 1 = MEM, 2 = WB).
- RF_WRITE_THROUGH, 1: 1 = register file writes on the inverted clock, so the oldest entry is never forwarded; 0 = all entries forwardable.
- CNT_W, 16: width of the performance counters.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  read addresses (Rn, Reg2Loc-selected second operand).
- id_rs1_used, id_rs2_used  in  1  the corresponding operand is consumed.
- id_rd  in  REG_AW  destination address.
- id_reg_write, id_is_load, id_sets_flags, id_uses_flags  in  1  decode attributes.
- br_taken  in  1  branch in EX resolved taken this cycle.
- stall  out  1  hold PC and the IF/ID register, and inject a bubble into ID/EX.
- flush  out  1  squash the IF/ID contents, and inject a bubble into ID/EX.
- fwd_sel1, fwd_sel2  out  $clog2(FWD_DEPTH+1)  0 = register file; k = entry k-1.
- fwd_flags  out  1  B.cond must use live ALU flags rather than the stored flags.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Shadow pipeline: FWD_DEPTH entries, each holding {valid, rd, reg_write, is_load, sets_flags}.
- Each clock, entry k shifts into entry k+1 and the oldest entry retires.
- Entry 0 loads the decode attributes when id_valid is high and neither stall nor flush is asserted; otherwise it loads a bubble (valid = 0).
- Match on an operand: entry valid, reg_write set, rd equal to the source address, source address not equal to ZERO_REG, and the operand's _used bit set.
- fwd_selN is the youngest matching forwardable entry. It is 0 when nothing matches, or when the only match is the oldest entry and RF_WRITE_THROUGH = 1.
- Load-use: a match on entry 0 with is_load set asserts stall. The bubble then enters EX, the load moves to MEM, and the next cycle forwards from entry 1. The penalty is exactly one cycle.
- fwd_flags = id_uses_flags and entry 0 valid with sets_flags.
- flush = br_taken. Flush has priority over stall: when both are true, stall is driven 0 and the decode instruction is discarded.
- stall and flush are gated by id_valid; a bubble in ID never stalls.
- Counters increment once per cycle in which stall (respectively flush) is high, and saturate at all-ones.

## Timing
- stall, flush, fwd_sel* and fwd_flags are combinational from the current inputs and shadow state, and must settle before the rising clk edge.
- Shadow entries and counters update on the rising clk edge.
- Reset, asynchronous: all entries invalid and both counters 0. Consequently stall = 0, flush = 0, fwd_sel* = 0 and fwd_flags = 0 while reset is high.
- Reset asserted mid-stall clears the interlock immediately; the first cycle after release decodes with no hazards.
- Back-to-back loads with dependent consumers each take an independent one-cycle stall.
- A stalled instruction re-evaluates every cycle with unchanged ID inputs.

## Structure
- Shared package pipe_pkg holds:
  - the shadow-entry struct typedef;
  - the ZERO_REG default;
  - the fwd_sel encoding constants FWD_RF, FWD_EX, FWD_MEM and FWD_WB.
- The parametrised matcher is a natural sub-module, fwd_match:
  - inputs: one source address plus the entry array;
  - outputs: the selected index and a load-hit flag;
  - instantiated twice, once per read port.

## Test plan
- ADD X1,X2,X3 followed by SUB X4,X1,X5 → fwd_sel1 = 1 on the SUB in ID; stall = 0.
- LDUR X1 followed by ADD X2,X1,X1 → stall = 1 for exactly one cycle. Next cycle fwd_sel1 = fwd_sel2 = 2, and stall_cnt = 1.
- ADD X31,… then ADD X5,X31,X31 → fwd_sel* = 0, no stall.
- Producer three instructions ahead with RF_WRITE_THROUGH = 1 → fwd_sel = 0. Repeat with 0 → fwd_sel = 3.
- br_taken together with a load-use condition → flush = 1, stall = 0, entry 0 is a bubble next cycle, and flush_cnt increments.
- Force 2^CNT_W+5 stalls → stall_cnt holds 0xFFFF.
- Assert reset mid-stall → all outputs are 0 immediately.
